calc_port_engine: RTL and testbench

//   Responder side of one calculator request/response port: the engine behind

---
 rtl/calc_port_engine.sv | 231 +++++++++++++++++++++++
 tb/tb_calc_port_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_port_engine.sv
// Responder engine for one calculator request/response port.
// Two-beat requests (cmd+op1, then op2) are captured, queued in a small FIFO,
// executed in order with a fixed latency and answered with a one-cycle response.
module calc_port_engine #(
    parameter int QDEPTH   = 4,  // request FIFO entries, power of 2, >= 2
    parameter int EXEC_LAT = 2   // cycles from FIFO pop to response cycle, >= 1
) (
    input  logic                      c_clk,
    input  logic                      reset,
    input  logic [3:0]                req_cmd_in,
    input  logic [31:0]               req_data_in,
    output logic [1:0]                out_resp,
    output logic [31:0]               out_data,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      drop_sticky
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int LW = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
    localparam logic [LW-1:0] RUN_LAST = LW'((EXEC_LAT > 1) ? EXEC_LAT - 2 : 0);
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    localparam logic [1:0] RESP_OK   = 2'b01;
    localparam logic [1:0] RESP_OVF  = 2'b10;
    localparam logic [1:0] RESP_BAD  = 2'b11;

    typedef enum logic {CAP_IDLE, CAP_OP2} cap_state_e;
    typedef enum logic [1:0] {EX_IDLE, EX_RUN, EX_RESP} ex_state_e;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
    } entry_t;

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    cap_state_e  cap_state_q, cap_state_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [31:0] op1_q, op1_d;
    logic        push;
    entry_t      push_entry;

    // Next-state logic: beat 1 latches cmd/op1, beat 2 pushes the full entry.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        cap_state_d = cap_state_q;
        cmd_d       = cmd_q;
        op1_d       = op1_q;
        push        = 1'b0;
        push_entry  = '{cmd: cmd_q, op1: op1_q, op2: req_data_in};
        case (cap_state_q)
            CAP_IDLE: begin
                if (req_cmd_in != 4'd0) begin
                    cap_state_d = CAP_OP2;
                    cmd_d       = req_cmd_in;
                    op1_d       = req_data_in;
                end
            end
            CAP_OP2: begin
                push        = 1'b1;
                cap_state_d = CAP_IDLE;
            end
            default: cap_state_d = CAP_IDLE;
        endcase
    end

    // Capture state register.
    always_ff @(posedge c_clk) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // the values from before the edge, independent of statement order.
        if (reset) begin
            cap_state_q <= CAP_IDLE;
            cmd_q       <= '0;
            op1_q       <= '0;
        end else begin
            cap_state_q <= cap_state_d;
            cmd_q       <= cmd_d;
            op1_q       <= op1_d;
        end
    end

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    entry_t          mem [QDEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            drop_q;
    ex_state_e       ex_state_q, ex_state_d;
    logic            full, empty, pop, push_ok, drop;
    entry_t          head;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign pop     = (ex_state_q == EX_IDLE) && !empty;
    // A push into a full queue survives only if the head leaves this cycle.
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign head    = mem[rd_ptr_q];

    // FIFO storage write.
    always_ff @(posedge c_clk) begin
        // NOTE: the storage array has no reset; entries are only ever read
        // behind the occupancy count, so stale contents are never observed.
        if (push_ok) begin
            mem[wr_ptr_q] <= push_entry;
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop) drop_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Arithmetic on the queue head
    // ------------------------------------------------------------------
    logic [32:0] sum;
    logic [1:0]  res_resp;
    logic [31:0] res_data;

    // Result of the head entry; only consumed on the cycle it is popped.
    always_comb begin
        sum      = {1'b0, head.op1} + {1'b0, head.op2};
        res_resp = RESP_BAD;
        res_data = '0;
        case (head.cmd)
            4'd1: begin
                if (sum[32]) begin
                    res_resp = RESP_OVF;
                end else begin
                    res_resp = RESP_OK;
                    res_data = sum[31:0];
                end
            end
            4'd2: begin
                if (head.op1 < head.op2) begin
                    res_resp = RESP_OVF;
                end else begin
                    res_resp = RESP_OK;
                    res_data = head.op1 - head.op2;
                end
            end
            4'd5: begin
                res_resp = RESP_OK;
                res_data = head.op1 << head.op2[4:0];
            end
            4'd6: begin
                res_resp = RESP_OK;
                res_data = head.op1 >> head.op2[4:0];
            end
            default: begin
                res_resp = RESP_BAD;
                res_data = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Exec FSM
    // ------------------------------------------------------------------
    logic [LW-1:0] run_cnt_q, run_cnt_d;
    logic [1:0]    resp_q, resp_d;
    logic [31:0]   data_q, data_d;

    // Next-state logic: pop when idle, wait out the latency, respond once.
    always_comb begin
        ex_state_d = ex_state_q;
        run_cnt_d  = run_cnt_q;
        resp_d     = resp_q;
        data_d     = data_q;
        case (ex_state_q)
            EX_IDLE: begin
                if (pop) begin
                    resp_d     = res_resp;
                    data_d     = res_data;
                    run_cnt_d  = '0;
                    ex_state_d = (EXEC_LAT == 1) ? EX_RESP : EX_RUN;
                end
            end
            EX_RUN: begin
                if (run_cnt_q == RUN_LAST) begin
                    ex_state_d = EX_RESP;
                end else begin
                    run_cnt_d = run_cnt_q + LW'(1);
                end
            end
            EX_RESP: ex_state_d = EX_IDLE;
            default: ex_state_d = EX_IDLE;
        endcase
    end

    // Exec state register and held result.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            ex_state_q <= EX_IDLE;
            run_cnt_q  <= '0;
            resp_q     <= '0;
            data_q     <= '0;
        end else begin
            ex_state_q <= ex_state_d;
            run_cnt_q  <= run_cnt_d;
            resp_q     <= resp_d;
            data_q     <= data_d;
        end
    end

    assign out_resp    = (ex_state_q == EX_RESP) ? resp_q : 2'b00;
    assign out_data    = (ex_state_q == EX_RESP) ? data_q : 32'd0;
    assign q_count     = count_q;
    assign drop_sticky = drop_q;

endmodule

// File: tb/tb_calc_port_engine.sv
// Self-checking bench for calc_port_engine: a transaction-level model
// (request queue + response time stamps) is compared every cycle, and
// directed vectors carry hand-computed literal expectations.
module tb_calc_port_engine;

    localparam int QDEPTH   = 4;
    localparam int EXEC_LAT = 2;

    logic                    c_clk = 1'b0;
    logic                    reset;
    logic [3:0]              req_cmd_in;
    logic [31:0]             req_data_in;
    logic [1:0]              out_resp;
    logic [31:0]             out_data;
    logic [$clog2(QDEPTH):0] q_count;
    logic                    drop_sticky;

    calc_port_engine #(.QDEPTH(QDEPTH), .EXEC_LAT(EXEC_LAT)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .q_count     (q_count),
        .drop_sticky (drop_sticky)
    );

    always #5 c_clk = ~c_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]  r;
        logic [31:0] d;
    } res_t;

    function automatic res_t calc(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        res_t   res;
        longint s;
        res.r = 2'b11;
        res.d = 0;
        case (cmd)
            4'd1: begin
                s = longint'(a) + longint'(b);
                if (s > 64'hFFFF_FFFF) res.r = 2'b10;
                else begin res.r = 2'b01; res.d = 32'(s); end
            end
            4'd2: begin
                if (a < b) res.r = 2'b10;
                else begin res.r = 2'b01; res.d = a - b; end
            end
            4'd5: begin res.r = 2'b01; res.d = a << (b % 32); end
            4'd6: begin res.r = 2'b01; res.d = a >> (b % 32); end
            default: ;
        endcase
        return res;
    endfunction

    res_t        mq[$];        // results of queued requests, in order
    res_t        m_res;        // result currently being executed
    bit          m_active;     // an entry has been popped and not yet answered
    int          m_resp_cycle; // cycle index on which m_res is presented
    int          cyc;
    bit          m_drop;
    bit          pend;
    logic [3:0]  pend_cmd;
    logic [31:0] pend_op1;

    // Model advance on every edge, using the inputs presented before it.
    always @(posedge c_clk) begin
        bit idle;
        bit popped;
        int sz;
        if (reset) begin
            mq.delete();
            m_active = 0;
            m_drop   = 0;
            pend     = 0;
            cyc      = 0;
        end else begin
            idle   = !m_active;
            popped = 0;
            if (m_active && cyc == m_resp_cycle) m_active = 0;
            sz = mq.size();
            if (idle && sz > 0) begin
                m_res        = mq.pop_front();
                m_active     = 1;
                m_resp_cycle = cyc + EXEC_LAT;
                popped       = 1;
            end
            if (pend) begin
                pend = 0;
                if (sz == QDEPTH && !popped) m_drop = 1;
                else mq.push_back(calc(pend_cmd, pend_op1, req_data_in));
            end else if (req_cmd_in != 4'd0) begin
                pend     = 1;
                pend_cmd = req_cmd_in;
                pend_op1 = req_data_in;
            end
            cyc++;
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison against the model, plus response logging
    // ------------------------------------------------------------------
    bit          cmp_en = 0;
    logic [31:0] resp_log[$];
    int          max_q = 0;

    always @(negedge c_clk) begin
        logic [1:0]  e_r;
        logic [31:0] e_d;
        if (cmp_en) begin
            e_r = (m_active && cyc == m_resp_cycle) ? m_res.r : 2'b00;
            e_d = (m_active && cyc == m_resp_cycle) ? m_res.d : 32'd0;
            check("model_resp", 64'(out_resp), 64'(e_r));
            check("model_data", 64'(out_data), 64'(e_d));
            check("model_qcount", 64'(q_count), 64'(mq.size()));
            check("model_drop", 64'(drop_sticky), 64'(m_drop));
            if (out_resp == 2'b01) resp_log.push_back(out_data);
            if (int'(q_count) > max_q) max_q = int'(q_count);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    // One request into an idle engine; response expected on cycle N+4, gone on N+5.
    task automatic single(input string name, input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed);
        step(); req_cmd_in = cmd;  req_data_in = a;   // cycle N
        step(); req_cmd_in = 4'd0; req_data_in = b;   // N+1
        step(); req_data_in = 32'd0;                  // N+2
        step();                                       // N+3
        @(negedge c_clk);
        check({name, "_early"}, 64'(out_resp), 64'd0);
        step();                                       // N+4
        @(negedge c_clk);
        check({name, "_resp"}, 64'(out_resp), 64'(er));
        check({name, "_data"}, 64'(out_data), 64'(ed));
        step();                                       // N+5
        @(negedge c_clk);
        check({name, "_resp_after"}, 64'(out_resp), 64'd0);
        check({name, "_data_after"}, 64'(out_data), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ordered;
        reset       = 1'b1;
        req_cmd_in  = 4'd0;
        req_data_in = 32'd0;
        @(posedge c_clk);
        #1 cmp_en = 1;
        repeat (2) step();
        reset = 1'b0;
        @(negedge c_clk);
        check("reset_resp", 64'(out_resp), 64'd0);
        check("reset_data", 64'(out_data), 64'd0);
        check("reset_qcount", 64'(q_count), 64'd0);
        check("reset_drop", 64'(drop_sticky), 64'd0);

        single("add",       4'd1, 32'h5,         32'h1,  2'b01, 32'h6);
        single("add_ovf",   4'd1, 32'hFFFF_FFFF, 32'h1,  2'b10, 32'h0);
        single("sub_under", 4'd2, 32'h22,        32'h23, 2'b10, 32'h0);
        single("sub",       4'd2, 32'h23,        32'h22, 2'b01, 32'h1);
        single("shl",       4'd5, 32'h3,         32'h2,  2'b01, 32'hC);
        single("shr",       4'd6, 32'hC,         32'h2,  2'b01, 32'h3);
        single("shl_wrap",  4'd5, 32'h3,         32'h21, 2'b01, 32'h6);
        single("invalid",   4'd3, 32'h7,         32'h8,  2'b11, 32'h0);

        // cmd 0 is a no-op and must never produce a response.
        step(); req_cmd_in = 4'd0; req_data_in = 32'h64;
        for (int i = 0; i < 10; i++) begin
            step(); req_data_in = 32'd0;
            @(negedge c_clk);
            check("nop_no_resp", 64'(out_resp), 64'd0);
        end

        // Back-to-back adds i+i, i=1..16: arrivals every 2 cycles outpace one
        // service per 3 cycles, so the queue fills; requests 13 and 16 arrive
        // when it is full with no pop on that cycle and are lost.
        resp_log.delete();
        max_q = 0;
        for (int i = 1; i <= 16; i++) begin
            step(); req_cmd_in = 4'd1; req_data_in = 32'(i);
            step(); req_cmd_in = 4'd0; req_data_in = 32'(i);
        end
        step(); req_data_in = 32'd0;
        repeat (40) step();
        @(negedge c_clk);
        check("b2b_count", 64'(resp_log.size()), 64'd14);
        if (resp_log.size() == 14) begin
            check("b2b_first", 64'(resp_log[0]), 64'd2);
            check("b2b_12th", 64'(resp_log[11]), 64'd24);
            check("b2b_13th", 64'(resp_log[12]), 64'd28);
            check("b2b_last", 64'(resp_log[13]), 64'd30);
        end
        ordered = 1;
        for (int i = 1; i < resp_log.size(); i++)
            if (resp_log[i] <= resp_log[i-1]) ordered = 0;
        check("b2b_in_order", 64'(ordered), 64'd1);
        check("b2b_max_q", 64'(max_q), 64'(QDEPTH));
        check("b2b_drop_sticky", 64'(drop_sticky), 64'd1);
        check("b2b_q_drained", 64'(q_count), 64'd0);

        // Reset while an add is in EX_RUN: the add is never answered.
        step(); req_cmd_in = 4'd1; req_data_in = 32'h10;  // N
        step(); req_cmd_in = 4'd0; req_data_in = 32'h20;  // N+1
        step(); req_data_in = 32'd0;                      // N+2, popped here
        step(); reset = 1'b1;                             // N+3, in EX_RUN
        step(); reset = 1'b0;
        @(negedge c_clk);
        check("rst_run_drop_cleared", 64'(drop_sticky), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge c_clk);
            check("rst_run_no_resp", 64'(out_resp), 64'd0);
            check("rst_run_qcount", 64'(q_count), 64'd0);
            step();
        end
        single("after_rst", 4'd1, 32'h7, 32'h8, 2'b01, 32'hF);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
